// File: rtl/icache_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : icache_pkg
//  Description : Shared constants for the instruction cache: boolean
//                constants, FSM state encodings and the default geometry.
//  Revision    : 1.0 - initial release
// ============================================================================
package icache_pkg;

    // Boolean constants shared with the rest of the core
    localparam logic c_TRUE  = 1'b1;
    localparam logic c_FALSE = 1'b0;

    // Cache geometry: log2 of the number of one-word lines
    localparam int c_DEFAULT_INDEX_BITS = 6;

    // Controller FSM state encodings
    localparam int         c_STATE_W       = 2;
    localparam logic [1:0] c_ST_IDLE       = 2'd0;
    localparam logic [1:0] c_ST_MISS       = 2'd1;
    // Fill still outstanding but its data must not be returned to fetch
    localparam logic [1:0] c_ST_DISCARD    = 2'd2;

endpackage : icache_pkg
`default_nettype wire

// File: rtl/icache_array.sv
`default_nettype none
// ============================================================================
//  Module      : icache_array
//  Description : Direct-mapped line storage. Combinational read port indexed
//                by the fetch address, one synchronous write port for fills,
//                per-line valid bits cleared synchronously by rst.
//  Ports       : clk, rst       - clock / synchronous active-high reset
//                i_rdy          - global enable, writes only when high
//                i_rd_index     - read line index
//                o_rd_valid/tag/data - contents of the indexed line
//                i_wr_en, i_wr_index, i_wr_tag, i_wr_data - fill port
//  Revision    : 1.0 - initial release
// ============================================================================
module icache_array
    import icache_pkg::*;
#(
    parameter int INDEX_BITS = c_DEFAULT_INDEX_BITS,
    parameter int TAG_BITS   = 32 - INDEX_BITS - 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_rdy,
    input  logic [INDEX_BITS-1:0] i_rd_index,
    output logic                  o_rd_valid,
    output logic [TAG_BITS-1:0]   o_rd_tag,
    output logic [31:0]           o_rd_data,
    input  logic                  i_wr_en,
    input  logic [INDEX_BITS-1:0] i_wr_index,
    input  logic [TAG_BITS-1:0]   i_wr_tag,
    input  logic [31:0]           i_wr_data
);

    localparam int c_LINES = 1 << INDEX_BITS;

    logic [c_LINES-1:0]  r_valid;
    logic [TAG_BITS-1:0] r_tag  [c_LINES];
    logic [31:0]         r_data [c_LINES];

    // Reset wins over a fill landing in the same cycle, so a fill that is
    // in flight when rst arrives never leaves a valid line behind.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
        end else if (i_rdy && i_wr_en) begin
            r_valid[i_wr_index] <= c_TRUE;
        end
    end

    // Tag/data need no reset; they are qualified by the valid bit.
    always_ff @(posedge clk) begin
        if (!rst && i_rdy && i_wr_en) begin
            r_tag[i_wr_index]  <= i_wr_tag;
            r_data[i_wr_index] <= i_wr_data;
        end
    end

    assign o_rd_valid = r_valid[i_rd_index];
    assign o_rd_tag   = r_tag[i_rd_index];
    assign o_rd_data  = r_data[i_rd_index];

endmodule : icache_array
`default_nettype wire

// File: rtl/icache.sv
`default_nettype none
// ============================================================================
//  Module      : icache
//  Description : Direct-mapped instruction cache, one 32-bit word per line.
//                Hits return in one cycle; misses issue a level request to
//                the memory controller and return the fill data. A flush
//                (clear) during a miss lets the fill complete into the array
//                but suppresses the response.
//  Ports       : clk, rst            - clock / synchronous active-high reset
//                rdy                 - global enable, all state holds when 0
//                clear               - pipeline flush, abandons pending fetch
//                fetch_req, fetch_pc - level request + word-aligned address
//                ins_ok, ins         - one-cycle response pulse + instruction
//                mem_req, mem_addr   - fill request / address to memory
//                mem_ok, mem_ins     - fill completion / fill data
//  Revision    : 1.0 - initial release
// ============================================================================
module icache
    import icache_pkg::*;
#(
    parameter int INDEX_BITS = c_DEFAULT_INDEX_BITS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        clear,
    input  logic        fetch_req,
    input  logic [31:0] fetch_pc,
    output logic        ins_ok,
    output logic [31:0] ins,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ok,
    input  logic [31:0] mem_ins
);

    localparam int c_TAG_BITS = 32 - INDEX_BITS - 2;

    logic [c_STATE_W-1:0] r_state;
    logic                 r_ins_ok;
    logic [31:0]          r_ins;
    logic                 r_mem_req;
    logic [31:0]          r_mem_addr;

    logic                  w_rd_valid;
    logic [c_TAG_BITS-1:0] w_rd_tag;
    logic [31:0]           w_rd_data;
    logic                  w_hit;
    logic                  w_accept;
    logic                  w_fill;
    logic                  w_unused_addr_lsbs;

    // Fills always target the address captured when the miss was issued.
    icache_array #(
        .INDEX_BITS (INDEX_BITS),
        .TAG_BITS   (c_TAG_BITS)
    ) u_array (
        .clk        (clk),
        .rst        (rst),
        .i_rdy      (rdy),
        .i_rd_index (fetch_pc[INDEX_BITS+1:2]),
        .o_rd_valid (w_rd_valid),
        .o_rd_tag   (w_rd_tag),
        .o_rd_data  (w_rd_data),
        .i_wr_en    (w_fill),
        .i_wr_index (r_mem_addr[INDEX_BITS+1:2]),
        .i_wr_tag   (r_mem_addr[31:INDEX_BITS+2]),
        .i_wr_data  (mem_ins)
    );

    assign w_hit = w_rd_valid && (w_rd_tag == fetch_pc[31:INDEX_BITS+2]);

    // A request is not taken while a response is being presented, otherwise
    // the still-held fetch_pc would be answered twice.
    assign w_accept = fetch_req && !clear && !r_ins_ok;

    // mem_ok outside MISS/DISCARD is not ours and must not touch the array.
    assign w_fill = mem_ok && ((r_state == c_ST_MISS) || (r_state == c_ST_DISCARD));

    // Word-aligned addresses: the byte offset bits carry no information.
    assign w_unused_addr_lsbs = ^{fetch_pc[1:0], r_mem_addr[1:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_ST_IDLE;
            r_ins_ok   <= c_FALSE;
            r_ins      <= '0;
            r_mem_req  <= c_FALSE;
            r_mem_addr <= '0;
        end else if (rdy) begin
            r_ins_ok <= c_FALSE;
            case (r_state)
                c_ST_IDLE: begin
                    if (w_accept) begin
                        if (w_hit) begin
                            r_ins    <= w_rd_data;
                            r_ins_ok <= c_TRUE;
                        end else begin
                            r_mem_addr <= fetch_pc;
                            r_mem_req  <= c_TRUE;
                            r_state    <= c_ST_MISS;
                        end
                    end
                end
                c_ST_MISS: begin
                    if (mem_ok) begin
                        // Line is written either way; only a flush in the
                        // same cycle suppresses the response.
                        r_mem_req <= c_FALSE;
                        r_state   <= c_ST_IDLE;
                        if (!clear) begin
                            r_ins    <= mem_ins;
                            r_ins_ok <= c_TRUE;
                        end
                    end else if (clear) begin
                        // Memory request cannot be withdrawn; wait it out.
                        r_state <= c_ST_DISCARD;
                    end
                end
                c_ST_DISCARD: begin
                    if (mem_ok) begin
                        r_mem_req <= c_FALSE;
                        r_state   <= c_ST_IDLE;
                    end
                end
                default: begin
                    r_mem_req <= c_FALSE;
                    r_state   <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign ins_ok   = r_ins_ok;
    assign ins      = r_ins;
    assign mem_req  = r_mem_req;
    assign mem_addr = r_mem_addr;

endmodule : icache
`default_nettype wire

// File: tb/tb_icache.sv
`default_nettype none
// ============================================================================
//  Module      : tb_icache
//  Description : Self-checking bench for icache. Expected instruction words
//                are queued when a response is provoked and compared by a
//                monitor whenever ins_ok pulses; each scenario task also
//                checks handshake timing inline.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_icache;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        clear;
    logic        fetch_req;
    logic [31:0] fetch_pc;
    logic        ins_ok;
    logic [31:0] ins;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ok;
    logic [31:0] mem_ins;

    logic [31:0] exp_q [$];
    logic [31:0] mon_exp;
    int          n_checks = 0;
    int          n_fail   = 0;

    always #5 clk = ~clk;

    icache dut (
        .clk       (clk),
        .rst       (rst),
        .rdy       (rdy),
        .clear     (clear),
        .fetch_req (fetch_req),
        .fetch_pc  (fetch_pc),
        .ins_ok    (ins_ok),
        .ins       (ins),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_ok    (mem_ok),
        .mem_ins   (mem_ins)
    );

    // Scoreboard: every ins_ok pulse must match the oldest queued word.
    always @(negedge clk) begin
        if (ins_ok === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_response: ins_ok=1 ins=%h, required no response", ins);
            end else begin
                mon_exp = exp_q.pop_front();
                if (ins !== mon_exp) begin
                    n_fail++;
                    $display("FAIL response_data: ins=%h, required %h", ins, mon_exp);
                end
            end
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) step();
        n_checks++;
        if (ins_ok !== 1'b0) begin n_fail++; $display("FAIL reset_ins_ok: got %b, required 0", ins_ok); end
        n_checks++;
        if (ins !== 32'h0) begin n_fail++; $display("FAIL reset_ins: got %h, required 0", ins); end
        n_checks++;
        if (mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req: got %b, required 0", mem_req); end
        n_checks++;
        if (mem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_mem_addr: got %h, required 0", mem_addr); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_cold_miss();
        fetch_req = 1'b1; fetch_pc = 32'h0000_0010;
        step();
        n_checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h10 || ins_ok !== 1'b0) begin
            n_fail++; $display("FAIL cold_miss_req: mem_req=%b mem_addr=%h ins_ok=%b, required 1/00000010/0", mem_req, mem_addr, ins_ok);
        end
        step(); step();
        n_checks++;
        if (mem_req !== 1'b1) begin n_fail++; $display("FAIL cold_miss_hold: mem_req=%b, required 1", mem_req); end
        mem_ok = 1'b1; mem_ins = 32'h0000_0513; exp_q.push_back(32'h0000_0513);
        step();
        n_checks++;
        if (ins_ok !== 1'b1 || mem_req !== 1'b0) begin
            n_fail++; $display("FAIL cold_miss_done: ins_ok=%b mem_req=%b, required 1/0", ins_ok, mem_req);
        end
        fetch_req = 1'b0; mem_ok = 1'b0; mem_ins = 32'hDEAD_BEEF;
        step();
        n_checks++;
        if (ins_ok !== 1'b0) begin n_fail++; $display("FAIL cold_miss_pulse: ins_ok=%b, required 0", ins_ok); end
    endtask

    task automatic test_hit_refetch();
        fetch_req = 1'b1; fetch_pc = 32'h0000_0010; exp_q.push_back(32'h0000_0513);
        step();
        n_checks++;
        if (ins_ok !== 1'b1 || mem_req !== 1'b0) begin
            n_fail++; $display("FAIL hit_latency: ins_ok=%b mem_req=%b, required 1/0", ins_ok, mem_req);
        end
        // Request still held: must not be answered a second time.
        step();
        n_checks++;
        if (ins_ok !== 1'b0 || mem_req !== 1'b0) begin
            n_fail++; $display("FAIL hit_no_double: ins_ok=%b mem_req=%b, required 0/0", ins_ok, mem_req);
        end
        fetch_req = 1'b0;
        step();
    endtask

    task automatic test_conflict();
        fetch_req = 1'b1; fetch_pc = 32'h0000_0110;
        step();
        n_checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h110) begin
            n_fail++; $display("FAIL conflict_miss: mem_req=%b mem_addr=%h, required 1/00000110", mem_req, mem_addr);
        end
        mem_ok = 1'b1; mem_ins = 32'h0040_0093; exp_q.push_back(32'h0040_0093);
        step();
        n_checks++;
        if (ins_ok !== 1'b1) begin n_fail++; $display("FAIL conflict_fill: ins_ok=%b, required 1", ins_ok); end
        mem_ok = 1'b0; fetch_pc = 32'h0000_0010;
        step();
        n_checks++;
        if (ins_ok !== 1'b0 || mem_req !== 1'b0) begin
            n_fail++; $display("FAIL conflict_gap: ins_ok=%b mem_req=%b, required 0/0", ins_ok, mem_req);
        end
        step();
        n_checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h10 || ins_ok !== 1'b0) begin
            n_fail++; $display("FAIL conflict_evicted: mem_req=%b mem_addr=%h ins_ok=%b, required 1/00000010/0", mem_req, mem_addr, ins_ok);
        end
        mem_ok = 1'b1; mem_ins = 32'h0000_0513; exp_q.push_back(32'h0000_0513);
        step();
        fetch_req = 1'b0; mem_ok = 1'b0;
        step();
    endtask

    task automatic test_clear();
        // Flush during a miss, fill arrives three cycles later.
        fetch_req = 1'b1; fetch_pc = 32'h0000_0020;
        step();
        fetch_req = 1'b0; clear = 1'b1;
        step();
        n_checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h20) begin
            n_fail++; $display("FAIL clear_miss_hold: mem_req=%b mem_addr=%h, required 1/00000020", mem_req, mem_addr);
        end
        clear = 1'b0;
        step(); step();
        mem_ok = 1'b1; mem_ins = 32'h1111_2222;
        step();
        n_checks++;
        if (ins_ok !== 1'b0 || mem_req !== 1'b0) begin
            n_fail++; $display("FAIL clear_discard: ins_ok=%b mem_req=%b, required 0/0", ins_ok, mem_req);
        end
        mem_ok = 1'b0; fetch_req = 1'b1; fetch_pc = 32'h0000_0020; exp_q.push_back(32'h1111_2222);
        step();
        n_checks++;
        if (ins_ok !== 1'b1 || mem_req !== 1'b0) begin
            n_fail++; $display("FAIL clear_refetch_hit: ins_ok=%b mem_req=%b, required 1/0", ins_ok, mem_req);
        end
        fetch_req = 1'b0;
        step();

        // Flush and fill completion in the same cycle.
        fetch_req = 1'b1; fetch_pc = 32'h0000_0030;
        step();
        fetch_req = 1'b0; clear = 1'b1; mem_ok = 1'b1; mem_ins = 32'h3333_4444;
        step();
        n_checks++;
        if (ins_ok !== 1'b0 || mem_req !== 1'b0) begin
            n_fail++; $display("FAIL clear_same_cycle: ins_ok=%b mem_req=%b, required 0/0", ins_ok, mem_req);
        end
        clear = 1'b0; mem_ok = 1'b0;
        fetch_req = 1'b1; fetch_pc = 32'h0000_0030; exp_q.push_back(32'h3333_4444);
        step();
        n_checks++;
        if (ins_ok !== 1'b1 || mem_req !== 1'b0) begin
            n_fail++; $display("FAIL clear_same_cycle_hit: ins_ok=%b mem_req=%b, required 1/0", ins_ok, mem_req);
        end
        fetch_req = 1'b0;
        step();

        // Stray mem_ok while idle must not write the line.
        mem_ok = 1'b1; mem_ins = 32'hBAD0_BAD0;
        step(); step();
        mem_ok = 1'b0;
        fetch_req = 1'b1; fetch_pc = 32'h0000_0030; exp_q.push_back(32'h3333_4444);
        step();
        n_checks++;
        if (ins_ok !== 1'b1 || mem_req !== 1'b0) begin
            n_fail++; $display("FAIL idle_mem_ok_ignored: ins_ok=%b mem_req=%b, required 1/0", ins_ok, mem_req);
        end
        fetch_req = 1'b0;
        step();

        // Flush while idle blocks acceptance for that cycle.
        fetch_req = 1'b1; fetch_pc = 32'h0000_0010; clear = 1'b1;
        step();
        n_checks++;
        if (ins_ok !== 1'b0 || mem_req !== 1'b0) begin
            n_fail++; $display("FAIL clear_idle: ins_ok=%b mem_req=%b, required 0/0", ins_ok, mem_req);
        end
        clear = 1'b0; exp_q.push_back(32'h0000_0513);
        step();
        n_checks++;
        if (ins_ok !== 1'b1) begin n_fail++; $display("FAIL clear_idle_after: ins_ok=%b, required 1", ins_ok); end
        fetch_req = 1'b0;
        step();
    endtask

    task automatic test_rdy_freeze();
        fetch_req = 1'b1; fetch_pc = 32'h0000_0050;
        step();
        rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            n_checks++;
            if (mem_req !== 1'b1 || mem_addr !== 32'h50 || ins_ok !== 1'b0) begin
                n_fail++; $display("FAIL rdy_freeze[%0d]: mem_req=%b mem_addr=%h ins_ok=%b, required 1/00000050/0", i, mem_req, mem_addr, ins_ok);
            end
        end
        rdy = 1'b1; mem_ok = 1'b1; mem_ins = 32'h5555_6666; exp_q.push_back(32'h5555_6666);
        step();
        n_checks++;
        if (ins_ok !== 1'b1 || mem_req !== 1'b0) begin
            n_fail++; $display("FAIL rdy_complete: ins_ok=%b mem_req=%b, required 1/0", ins_ok, mem_req);
        end
        fetch_req = 1'b0; mem_ok = 1'b0;
        step();
        n_checks++;
        if (ins_ok !== 1'b0) begin n_fail++; $display("FAIL rdy_single_pulse: ins_ok=%b, required 0", ins_ok); end
    endtask

    task automatic test_rst_mid_miss();
        fetch_req = 1'b1; fetch_pc = 32'h0000_0060;
        step();
        // Fill completes in the reset cycle and must be dropped.
        fetch_req = 1'b0; rst = 1'b1; mem_ok = 1'b1; mem_ins = 32'h6666_7777;
        step();
        n_checks++;
        if (mem_req !== 1'b0 || ins_ok !== 1'b0) begin
            n_fail++; $display("FAIL rst_mid_miss: mem_req=%b ins_ok=%b, required 0/0", mem_req, ins_ok);
        end
        rst = 1'b0; mem_ok = 1'b0;
        fetch_req = 1'b1; fetch_pc = 32'h0000_0010;
        step();
        n_checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h10 || ins_ok !== 1'b0) begin
            n_fail++; $display("FAIL rst_invalidates: mem_req=%b mem_addr=%h ins_ok=%b, required 1/00000010/0", mem_req, mem_addr, ins_ok);
        end
        mem_ok = 1'b1; mem_ins = 32'h0000_0513; exp_q.push_back(32'h0000_0513);
        step();
        mem_ok = 1'b0; fetch_pc = 32'h0000_0060;
        step();
        step();
        n_checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h60 || ins_ok !== 1'b0) begin
            n_fail++; $display("FAIL rst_drops_fill: mem_req=%b mem_addr=%h ins_ok=%b, required 1/00000060/0", mem_req, mem_addr, ins_ok);
        end
        mem_ok = 1'b1; mem_ins = 32'h7777_8888; exp_q.push_back(32'h7777_8888);
        step();
        fetch_req = 1'b0; mem_ok = 1'b0;
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; rdy = 1'b1; clear = 1'b0;
        fetch_req = 1'b0; fetch_pc = 32'h0;
        mem_ok = 1'b0; mem_ins = 32'h0;

        test_reset();
        test_cold_miss();
        test_hit_refetch();
        test_conflict();
        test_clear();
        test_rdy_freeze();
        test_rst_mid_miss();

        repeat (3) step();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++; $display("FAIL missing_responses: %0d outstanding, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_icache
`default_nettype wire
